// File: rtl/mul26_arbiter.sv
// Round-robin front end that shares one 26x26 signed multiplier between NREQ requesters.
// Each issued product is tagged with its requester id and parked in a response FIFO.
module mul26_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int MUL_LAT   = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [26*NREQ-1:0]   req_in1,
  input  logic [26*NREQ-1:0]   req_in2,
  output logic                 mul_en,
  output logic [25:0]          mul_in1,
  output logic [25:0]          mul_in2,
  input  logic [50:0]          mul_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [50:0]          rsp_data,
  output logic                 busy
);

  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int CRW = $clog2(RSP_DEPTH + MUL_LAT + 1);
  localparam int EW  = IDW + 51;

  logic [25:0]      in1_slice [NREQ];
  logic [25:0]      in2_slice [NREQ];

  logic [IDW-1:0]   rr_ptr_reg;
  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   cand;
  int               idx;
  logic             credit_ok;
  logic             issue;

  logic             stage_valid_reg [MUL_LAT];
  logic [IDW-1:0]   stage_id_reg    [MUL_LAT];
  logic [CRW-1:0]   inflight;
  logic [CRW-1:0]   cred;

  logic [EW-1:0]    fifo_mem [RSP_DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_next, rd_ptr_next;
  logic [CW-1:0]    count_reg;
  logic [EW-1:0]    head_reg;
  logic             push, pop;
  logic [EW-1:0]    push_entry;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign in1_slice[gi] = req_in1[26*gi +: 26];
      assign in2_slice[gi] = req_in2[26*gi +: 26];
    end
  endgenerate

  // Search upward from rr_ptr, wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < MUL_LAT; k++) inflight = inflight + CRW'(stage_valid_reg[k]);
  end

  // A pop in this same cycle is deliberately not counted back as credit.
  assign cred      = inflight + CRW'(count_reg);
  assign credit_ok = (cred < CRW'(RSP_DEPTH));
  assign issue     = !rst && grant_found && credit_ok;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant_id] = 1'b1;
  end

  assign mul_en  = |(req_valid & req_ready);
  assign mul_in1 = issue ? in1_slice[grant_id] : '0;
  assign mul_in2 = issue ? in2_slice[grant_id] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (mul_en) begin
      rr_ptr_reg <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  // Tag pipeline tracking each op through the multiplier latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MUL_LAT; k++) begin
        stage_valid_reg[k] <= 1'b0;
        stage_id_reg[k]    <= '0;
      end
    end else begin
      stage_valid_reg[0] <= mul_en;
      stage_id_reg[0]    <= grant_id;
      for (int k = 1; k < MUL_LAT; k++) begin
        stage_valid_reg[k] <= stage_valid_reg[k-1];
        stage_id_reg[k]    <= stage_id_reg[k-1];
      end
    end
  end

  assign push        = stage_valid_reg[MUL_LAT-1];
  assign push_entry  = {stage_id_reg[MUL_LAT-1], mul_out};
  assign rsp_valid   = !rst && (count_reg != '0);
  assign pop         = rsp_valid && rsp_ready;
  assign wr_ptr_next = (wr_ptr_reg == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
  assign rd_ptr_next = (rd_ptr_reg == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);

  always_ff @(posedge clk) begin
    if (push && !rst) fifo_mem[wr_ptr_reg] <= push_entry;
  end

  // head_reg is the registered FIFO output: refilled from the incoming push when
  // the FIFO is (or becomes) empty, otherwise from the next stored entry on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_next;
      if (pop)  rd_ptr_reg <= rd_ptr_next;
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
      if (count_reg == '0 || (pop && count_reg == CW'(1))) begin
        if (push) head_reg <= push_entry;
      end else if (pop) begin
        head_reg <= fifo_mem[rd_ptr_next];
      end
      assert (!(push && !pop && count_reg == CW'(RSP_DEPTH)));
    end
  end

  assign rsp_id   = head_reg[EW-1:51];
  assign rsp_data = head_reg[50:0];
  assign busy     = !rst && (cred != '0);

endmodule

// File: tb/tb_mul26_arbiter.sv
// Directed bench for mul26_arbiter with a one-cycle signed multiplier stand-in.
// Each scenario task drives its own vectors and compares against hand-computed values.
module tb_mul26_arbiter;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [103:0]       req_in1, req_in2;
  logic               mul_en;
  logic [25:0]        mul_in1, mul_in2;
  logic [50:0]        mul_out;
  logic               rsp_valid, rsp_ready;
  logic [1:0]         rsp_id;
  logic [50:0]        rsp_data;
  logic               busy;
  logic signed [51:0] mul_full;

  int errors = 0;
  int checks = 0;

  mul26_arbiter #(.NREQ(4), .IDW(2), .MUL_LAT(1), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .mul_en(mul_en), .mul_in1(mul_in1),
    .mul_in2(mul_in2), .mul_out(mul_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: loads its inputs every edge, product valid one cycle later.
  assign mul_full = $signed(mul_in1) * $signed(mul_in2);
  always @(posedge clk) mul_out <= mul_full[50:0];

  always @(negedge clk)
    if (!rst && rsp_valid && rsp_ready) $display("rsp id=%0d data=%h", rsp_id, rsp_data);

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [25:0] a, input logic [25:0] b);
    req_in1[26*i +: 26] = a;
    req_in2[26*i +: 26] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    set_op(0, 26'd1, 26'd1);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (mul_en !== 1'b0) begin errors++; $display("FAIL reset_mul_en: got %b expected 0", mul_en); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tick(); tick();
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
  endtask

  task automatic test_single();
    do_reset();
    set_op(0, 26'd3, 26'h3FFFFFB);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001 || mul_en !== 1'b1) begin errors++; $display("FAIL single_grant: got ready=%b en=%b expected 0001 1", req_ready, mul_en); end
    checks++; if (mul_in1 !== 26'd3 || mul_in2 !== 26'h3FFFFFB) begin errors++; $display("FAIL single_operands: got %h %h expected 0000003 3fffffb", mul_in1, mul_in2); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_inflight: got valid=%b busy=%b expected 0 1", rsp_valid, busy); end
    checks++; if (mul_in1 !== 26'd0 || mul_en !== 1'b0) begin errors++; $display("FAIL single_idle_operand: got in1=%h en=%b expected 0 0", mul_in1, mul_en); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp: got valid=%b id=%0d expected 1 0", rsp_valid, rsp_id); end
    checks++; if (rsp_data !== 51'h7_FFFF_FFFF_FFF1) begin errors++; $display("FAIL single_data: got %h expected 7fffffffffff1", rsp_data); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 51'h7_FFFF_FFFF_FFF1) begin errors++; $display("FAIL single_hold: got valid=%b data=%h expected 1 7fffffffffff1", rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drain: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    logic [50:0] exp_data [4];
    exp_data[0] = 51'd6; exp_data[1] = 51'd9; exp_data[2] = 51'd12; exp_data[3] = 51'd15;
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 26'(i + 2), 26'd3);
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) begin
        checks++; if (req_ready !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, 4'(1 << (c % 4))); end
      end
      if (c >= 2 && c < 10) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4) || rsp_data !== exp_data[(c - 2) % 4]) begin
          errors++;
          $display("FAIL rr_rsp c=%0d: got valid=%b id=%0d data=%h expected 1 %0d %h", c, rsp_valid, rsp_id, rsp_data, (c - 2) % 4, exp_data[(c - 2) % 4]);
        end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_idle c=%0d: got valid=%b expected 0", c, rsp_valid); end
      end
      tick();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int hs;
    logic [50:0] exp_data [4];
    exp_data[0] = 51'h7_FFFF_FFFF_FFFD; exp_data[1] = 51'h7_FFFF_FFFF_FFFA;
    exp_data[2] = 51'h7_FFFF_FFFF_FFF7; exp_data[3] = 51'h7_FFFF_FFFF_FFF4;
    do_reset();
    hs = 0;
    req_valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      set_op(0, 26'(hs + 1), 26'h3FFFFFD);
      #1;
      if (req_ready[0]) hs++;
      tick();
    end
    #1;
    checks++; if (hs !== 4) begin errors++; $display("FAIL bp_handshakes: got %0d expected 4", hs); end
    checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL bp_blocked: got ready=%b busy=%b expected 0000 1", req_ready, busy); end
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_data[0]) begin errors++; $display("FAIL bp_head_stable: got valid=%b data=%h expected 1 %h", rsp_valid, rsp_data, exp_data[0]); end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_data[k]) begin errors++; $display("FAIL bp_drain k=%0d: got valid=%b data=%h expected 1 %h", k, rsp_valid, rsp_data, exp_data[k]); end
      tick();
    end
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin errors++; $display("FAIL bp_reenable: got valid=%b ready=%b expected 0 0001", rsp_valid, req_ready); end
    req_valid = '0;
  endtask

  task automatic test_extremes();
    do_reset();
    set_op(0, 26'h2000000, 26'h1FFFFFF);
    set_op(1, 26'h2000000, 26'h3FFFFFF);
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ext_grant0: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ext_grant1: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 51'h4_0000_0200_0000) begin errors++; $display("FAIL ext_min_times_max: got valid=%b id=%0d data=%h expected 1 0 4000002000000", rsp_valid, rsp_id, rsp_data); end
    rsp_ready = 1'b1;
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 51'h0_0000_0200_0000) begin errors++; $display("FAIL ext_min_times_neg1: got valid=%b id=%0d data=%h expected 1 1 0000002000000", rsp_valid, rsp_id, rsp_data); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ext_empty: got valid=%b expected 0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_op(0, 26'd5, 26'd5);
    req_valid = 4'b0001;
    tick(); tick(); tick();
    #1;
    checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_setup: got valid=%b busy=%b expected 1 1", rsp_valid, busy); end
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 || mul_en !== 1'b0) begin errors++; $display("FAIL mid_rst_outputs: got valid=%b busy=%b ready=%b en=%b expected 0 0 0000 0", rsp_valid, busy, req_ready, mul_en); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after_rst: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rr_restart: got %b expected 0001", req_ready); end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale c=%0d: got valid=%b expected 0", c, rsp_valid); end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_rr_skip_and_full();
    int hs;
    int npop;
    do_reset();
    set_op(1, 26'd2, 26'd2);
    set_op(3, 26'd4, 26'd4);
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick(); tick();
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_first: got %b expected 1000", req_ready); end
    tick();
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL skip_second: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick(); tick();

    do_reset();
    set_op(0, 26'd1, 26'd7);
    req_valid = 4'b0001;
    hs = 0;
    for (int c = 0; c < 10 && hs < 4; c++) begin
      #1;
      if (req_ready[0]) hs++;
      tick();
    end
    #1;
    checks++; if (hs !== 4 || req_ready !== 4'b0000) begin errors++; $display("FAIL full_credit: got hs=%0d ready=%b expected 4 0000", hs, req_ready); end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b1) begin errors++; $display("FAIL full_pushpop_credit: got ready=%b valid=%b expected 0001 1", req_ready, rsp_valid); end
    req_valid = '0;
    rsp_ready = 1'b1;
    npop = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (rsp_valid) npop++;
      tick();
    end
    checks++; if (npop !== 3) begin errors++; $display("FAIL full_count_kept: got %0d pops expected 3", npop); end
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_in1 = '0; req_in2 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_extremes();
    test_reset_midflight();
    test_rr_skip_and_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
